johnson_count_decoder: RTL and testbench
========================================

# johnson_count_decoder

Receiving end of the decade counter interface produced by the ring-oscillator counters. Takes the three 5-bit Johnson-coded decade digits (hundreds, tens, ones) from an asynchronous oscillator domain and brings them into the i_clk domain. It filters them for stability, validates and decodes them to a binary count 0..999, and reports the modulo-1000 difference from the previously accepted count. It sits between a counter/capture pair and the scan/LED logic, or a host readout.

## Interface
- pCONFIRM, 4: number of consecutive identical synchronized samples required before a value is accepted; legal range 2..15.
- i_clk  in  1  system clock; all logic is in this domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_100  in  5  hundreds digit, Johnson code, asynchronous to i_clk.
- i_010  in  5  tens digit, Johnson code, asynchronous to i_clk.
- i_001  in  5  ones digit, Johnson code, asynchronous to i_clk.
- o_count  out  10  last accepted count, binary 0..999.
- o_delta  out  10  (o_count − previous accepted count) mod 1000.
- o_valid  out  1  one-cycle pulse when o_count/o_delta update.
- o_err  out  1  sticky: a stable sample contained an invalid digit code.

## Operation
- Digit code, 5-bit Johnson: 0=00000, 1=00001, 2=00011, 3=00111, 4=01111, 5=11111, 6=11110, 7=11100, 8=11000, 9=10000. The other 22 codes are invalid.
- Synchronizer: the 15 input bits pass through two flop stages, s1 then s2. Both stages reset to 0.
- Stability filter: r_prev holds the previous s2 and r_run is a 4-bit run counter.
  - If s2 equals r_prev, r_run increments and saturates at pCONFIRM.
  - If s2 differs, r_run clears to 0.
  - Stable event: the single cycle in which r_run transitions to pCONFIRM−1.
- Decode stage: on a stable event, the three digits are registered as 4-bit values plus a per-digit valid flag.
- Arithmetic stage: count = 100·h + 10·t + o, using 10-bit unsigned arithmetic.
  - If any digit is invalid: set o_err. o_count, o_delta and o_valid are unchanged.
  - If all digits are valid and count ≠ r_acc: set o_count = count and o_delta = (count − r_acc + 1000) mod 1000, pulse o_valid, and set r_acc = count.
  - If all digits are valid and count = r_acc: no pulse and no update.
- Wrap-around: 998 → 003 gives o_delta = 5. An equal count is never reported.
- o_err clears only on i_rst.

## Timing
- Reset values: o_count=0, o_delta=0, o_valid=0, o_err=0, r_acc=0, r_run=0, r_prev=0, s1=0, s2=0.
- Edge numbering: edge 0 is the first i_clk edge at which s1 samples a new steady input.
- Latency: o_valid is high in the cycle following edge pCONFIRM+3, which is edge 7 at the default. It stays high for exactly one cycle.
- An input change during the confirmation window restarts the window. Back-to-back accepted values are therefore at least pCONFIRM cycles apart.
- i_rst asserted mid-window or mid-pipeline:
  - All stages clear on that edge and any in-flight value is discarded.
  - A steady 000 input after reset never pulses, because r_acc=0.
- The stable event fires once per run. A run that continues past pCONFIRM does not retrigger.

## Test plan
- Reset, then hold digits 1/2/3 (00001/00011/00111) steady → one o_valid pulse after edge 7, o_count=123, o_delta=123, o_err=0.
- From 123, apply 4/5/6 → o_count=456, o_delta=333. Holding 456 for 50 further cycles produces no further pulse.
- From 998, apply 0/0/3 → o_count=3, o_delta=5 (wrap).
- Toggle the ones digit every 2 cycles for 20 cycles, then settle on 7 → exactly one pulse, for the settled value only.
- Apply the invalid tens code 01010 steadily → o_err=1, no pulse, o_count unchanged. A following valid value updates o_count while o_err stays 1.
- Assert i_rst at edge 3 of a confirmation window → no pulse. All outputs read 0 after the reset edge.

Source files
------------

// File: rtl/johnson_count_decoder.sv
// johnson_count_decoder
//   Brings three 5-bit Johnson-coded decade digits from an asynchronous
//   ring-oscillator counter into the i_clk domain. Each sample must stay
//   unchanged for pCONFIRM consecutive cycles before it is accepted. It is
//   then checked for valid digit codes, decoded to a binary count 0..999 and
//   compared with the previously accepted count.
//
// Ports
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_100    hundreds digit, Johnson code (async)
//   i_010    tens digit, Johnson code (async)
//   i_001    ones digit, Johnson code (async)
//   o_count  last accepted count, binary 0..999
//   o_delta  (o_count - previous accepted count) mod 1000
//   o_valid  one-cycle pulse when o_count/o_delta update
//   o_err    sticky flag: an accepted sample held an invalid digit code

// Per-digit Johnson decoder. This is a pure lookup. ok is low for the 22
// codes that a 5-stage Johnson counter never produces.
module johnson_digit_dec (
  input  logic [4:0] code,
  output logic [3:0] val,
  output logic       ok
);
  always_comb begin
    val = 4'd0;
    ok  = 1'b1;
    case (code)
      5'b00000: val = 4'd0;
      5'b00001: val = 4'd1;
      5'b00011: val = 4'd2;
      5'b00111: val = 4'd3;
      5'b01111: val = 4'd4;
      5'b11111: val = 4'd5;
      5'b11110: val = 4'd6;
      5'b11100: val = 4'd7;
      5'b11000: val = 4'd8;
      5'b10000: val = 4'd9;
      default:  ok  = 1'b0;
    endcase
  end
endmodule

module johnson_count_decoder #(
  parameter int pCONFIRM = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_100,
  input  logic [4:0] i_010,
  input  logic [4:0] i_001,
  output logic [9:0] o_count,
  output logic [9:0] o_delta,
  output logic       o_valid,
  output logic       o_err
);
  localparam int NUM_DIG = 3;           // [2]=hundreds [1]=tens [0]=ones
  localparam logic [3:0] RUN_MAX = 4'(pCONFIRM);
  localparam logic [3:0] RUN_PRE = 4'(pCONFIRM - 2);

  logic [NUM_DIG-1:0][4:0] din, s1, s2, r_prev, stb_val;
  logic [NUM_DIG-1:0][3:0] dec_val, dig_q;
  logic [NUM_DIG-1:0]      dec_ok, dig_ok;
  logic [3:0]              r_run;
  logic [1:0]              vld_pipe;    // [0] stable sample captured, [1] decoded
  logic                    same, stable;
  logic [9:0]              r_acc, count, delta;

  assign din = {i_100, i_010, i_001};

  // Two-flop synchronizer. Individual bits may resolve on different cycles
  // during a transition. The run filter below rejects those torn samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Run filter. The stable event is the single cycle in which r_run steps
  // from pCONFIRM-2 to pCONFIRM-1. r_run saturates at pCONFIRM, so a long
  // run never passes through that step a second time.
  assign same   = (s2 == r_prev);
  assign stable = same && (r_run == RUN_PRE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= '0;
      r_run  <= '0;
    end else begin
      r_prev <= s2;
      if (!same)                r_run <= '0;
      else if (r_run != RUN_MAX) r_run <= r_run + 4'd1;
    end
  end

  // Capture the confirmed sample, then decode it on the next cycle.
  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      johnson_digit_dec u_dec (
        .code (stb_val[g]),
        .val  (dec_val[g]),
        .ok   (dec_ok[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      stb_val  <= '0;
      dig_q    <= '0;
      dig_ok   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], stable};
      if (stable)      stb_val <= s2;
      if (vld_pipe[0]) begin
        dig_q  <= dec_val;
        dig_ok <= dec_ok;
      end
    end
  end

  // Arithmetic stage. All terms are at most 999, so 10 bits are enough.
  // The wrap branch can overflow in an intermediate step, but the final
  // result is always below 1000, so modulo-1024 arithmetic gives the right
  // value.
  assign count = 10'(dig_q[2]) * 10'd100 + 10'(dig_q[1]) * 10'd10 + 10'(dig_q[0]);
  assign delta = (count >= r_acc) ? (count - r_acc) : (count + 10'd1000 - r_acc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      o_delta <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (vld_pipe[1]) begin
        if (!(&dig_ok)) begin
          o_err <= 1'b1;
        end else if (count != r_acc) begin
          r_acc   <= count;
          o_delta <= delta;
          o_valid <= 1'b1;
        end
      end
    end
  end

  // The accepted count is the reference for the next delta. It is exported
  // directly so the two values can never disagree.
  assign o_count = r_acc;

endmodule

// File: tb/tb_johnson_count_decoder.sv
module tb_johnson_count_decoder;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_100, i_010, i_001;
  logic [9:0] o_count, o_delta;
  logic       o_valid, o_err;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int mark;
  logic v6, v7, v8;

  localparam logic [4:0] J [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                    5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  johnson_count_decoder #(.pCONFIRM(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_100(i_100), .i_010(i_010), .i_001(i_001),
    .o_count(o_count), .o_delta(o_delta), .o_valid(o_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic put(input int h, input int t, input int o);
    i_100 = J[h];
    i_010 = J[t];
    i_001 = J[o];
  endtask

  initial begin
    i_rst = 1'b1;
    put(0, 0, 0);
    tick(3);
    chk("rst_count", o_count, 0);
    chk("rst_delta", o_delta, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_err",   o_err,   0);
    i_rst = 1'b0;
    tick(10);
    chk("zero_no_pulse", pulses, 0);

    // 123: the pulse appears exactly after edge 7 and lasts one cycle
    put(1, 2, 3);
    tick(7); v6 = o_valid;     // after edge 6
    tick(1); v7 = o_valid;     // after edge 7
    tick(1); v8 = o_valid;     // after edge 8
    chk("lat_e6", v6, 0);
    chk("lat_e7", v7, 1);
    chk("lat_e8", v8, 0);
    chk("c123_count", o_count, 123);
    chk("c123_delta", o_delta, 123);
    chk("c123_err",   o_err,   0);
    chk("c123_pulses", pulses, 1);

    // 456, then hold it to confirm the run does not retrigger
    put(4, 5, 6);
    tick(12);
    chk("c456_count", o_count, 456);
    chk("c456_delta", o_delta, 333);
    mark = pulses;
    tick(50);
    chk("hold_no_pulse", pulses - mark, 0);

    // 998 then wrap to 003
    put(9, 9, 8);
    tick(12);
    chk("c998_count", o_count, 998);
    chk("c998_delta", o_delta, 542);
    put(0, 0, 3);
    tick(12);
    chk("wrap_count", o_count, 3);
    chk("wrap_delta", o_delta, 5);

    // ones digit toggles every 2 cycles, then settles on 7
    mark = pulses;
    for (int i = 0; i < 10; i++) begin
      put(0, 0, (i % 2 == 0) ? 1 : 2);
      tick(2);
    end
    chk("toggle_no_pulse", pulses - mark, 0);
    put(0, 0, 7);
    tick(12);
    chk("settle_pulses", pulses - mark, 1);
    chk("settle_count", o_count, 7);
    chk("settle_delta", o_delta, 4);

    // invalid tens code
    mark = pulses;
    i_010 = 5'b01010;
    tick(12);
    chk("inv_err",   o_err, 1);
    chk("inv_pulse", pulses - mark, 0);
    chk("inv_count", o_count, 7);
    put(5, 0, 0);
    tick(12);
    chk("post_inv_count", o_count, 500);
    chk("post_inv_delta", o_delta, 493);
    chk("post_inv_err",   o_err, 1);

    // reset sampled on edge 3 of a confirmation window
    mark = pulses;
    put(1, 2, 3);
    tick(3);                   // edges 0..2 done
    i_rst = 1'b1;
    put(0, 0, 0);
    tick(1);                   // edge 3
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_delta", o_delta, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_err",   o_err,   0);
    i_rst = 1'b0;
    tick(20);
    chk("mid_rst_no_pulse", pulses - mark, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
